// File: rtl/key_scan_if.sv
// key_scan_if: key event bus between the calibration key front-end
// (master) and the time-field counters (slave).
//   btn_out : active-low one-hot key code, 4'b1111 = idle
//   btn_pos : field cursor 0..3
interface key_scan_if;
    logic [3:0] btn_out;
    logic [1:0] btn_pos;

    modport master (output btn_out, output btn_pos);
    modport slave  (input  btn_out, input  btn_pos);
endinterface : key_scan_if

// File: rtl/key_scan.sv
// key_scan: calibration key front-end for the electronic clock.
// Synchronises and debounces four active-low keys (0 left, 1 right, 2 up,
// 3 down), emits one-cycle event codes on btn_out and moves the field
// cursor btn_pos while sw1 selects calibration mode.
// Optional build macro: KEY_AUTOREPEAT_EN adds auto-repeat of held up/down.
module key_scan #(
    parameter int DEB_CYCLES    = 20,
    parameter int REPEAT_DELAY  = 100,
    parameter int REPEAT_PERIOD = 25
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        sw1,
    input  logic [3:0]  key_raw,
    key_scan_if.master  bus
);

    localparam int             DW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_LIM = DW'(DEB_CYCLES);

    // Elaboration-time guard: every timing parameter must be at least one.
    if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_scan: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    stable_q, stable_d;
    // A key arms only after it has been seen released for DEB_CYCLES cycles
    // following reset, so a key held through reset cannot fire on release.
    logic [3:0]    arm_q, arm_d;
    logic [DW-1:0] cnt_q [4];
    logic [DW-1:0] cnt_d [4];
    logic [3:0]    press_q, press_d;
    logic [3:0]    btn_out_q, btn_out_d;
    logic [1:0]    btn_pos_q, btn_pos_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int             RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             HW         = $clog2(RMAX + 1);
    localparam logic [HW-1:0]  DELAY_LIM  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]  PERIOD_LIM = HW'(REPEAT_PERIOD);

    logic          hold_act_q, hold_act_d;
    logic          hold_key_q, hold_key_d;      // 0 = up, 1 = down
    logic          hold_first_q, hold_first_d;  // first repeat still pending
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_held_s;
    logic [HW-1:0] hold_lim_s;
`endif

    assign bus.btn_out = btn_out_q;
    assign bus.btn_pos = btn_pos_q;

    // Two-stage synchroniser for the asynchronous raw keys.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    // Per-key debounce: arm after reset, then accept a level change that persists DEB_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        arm_d    = arm_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!arm_q[i]) begin
                if (sync2_q[i]) begin
                    if ((cnt_q[i] + DW'(1'b1)) == DEB_LIM) begin
                        arm_d[i] = 1'b1;
                        cnt_d[i] = {DW{1'b0}};
                    end else begin
                        cnt_d[i] = cnt_q[i] + DW'(1'b1);
                    end
                end else begin
                    cnt_d[i] = {DW{1'b0}};
                end
            end else if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {DW{1'b0}};
            end else if ((cnt_q[i] + DW'(1'b1)) == DEB_LIM) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = {DW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1'b1);
            end
        end
        // A press is a stable 1->0 transition; releases generate nothing.
        press_d = stable_q & ~stable_d;
    end

`ifdef KEY_AUTOREPEAT_EN
    // Held-key status and current repeat interval for the auto-repeat counter.
    always_comb begin
        hold_held_s = hold_key_q ? ~stable_q[3] : ~stable_q[2];
        hold_lim_s  = hold_first_q ? DELAY_LIM : PERIOD_LIM;
    end
`endif

    // Event arbitration (up > down > right > left), mode gating and cursor update.
    always_comb begin
        btn_out_d = 4'b1111;
        btn_pos_d = btn_pos_q;
`ifdef KEY_AUTOREPEAT_EN
        hold_act_d   = 1'b0;
        hold_key_d   = hold_key_q;
        hold_first_d = hold_first_q;
        hold_cnt_d   = hold_cnt_q;
`endif
        if (!sw1) begin
            btn_pos_d = 2'd0;
        end else if (press_q[2]) begin
            btn_out_d = 4'b1011;
`ifdef KEY_AUTOREPEAT_EN
            hold_act_d   = 1'b1;
            hold_key_d   = 1'b0;
            hold_first_d = 1'b1;
            hold_cnt_d   = {HW{1'b0}};
`endif
        end else if (press_q[3]) begin
            btn_out_d = 4'b0111;
`ifdef KEY_AUTOREPEAT_EN
            hold_act_d   = 1'b1;
            hold_key_d   = 1'b1;
            hold_first_d = 1'b1;
            hold_cnt_d   = {HW{1'b0}};
`endif
        end else if (press_q[1]) begin
            btn_out_d = 4'b1101;
            btn_pos_d = btn_pos_q + 2'd1;
        end else if (press_q[0]) begin
            btn_out_d = 4'b1110;
            btn_pos_d = btn_pos_q - 2'd1;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
            if (hold_act_q && hold_held_s) begin
                hold_act_d = 1'b1;
                if ((hold_cnt_q + HW'(1'b1)) == hold_lim_s) begin
                    btn_out_d    = hold_key_q ? 4'b0111 : 4'b1011;
                    hold_cnt_d   = {HW{1'b0}};
                    hold_first_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1'b1);
                end
            end else begin
                hold_act_d = 1'b0;
            end
`else
            btn_out_d = 4'b1111;
`endif
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            stable_q  <= 4'b1111;
            arm_q     <= 4'b0000;
            press_q   <= 4'b0000;
            btn_out_q <= 4'b1111;
            btn_pos_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= {DW{1'b0}};
            end
`ifdef KEY_AUTOREPEAT_EN
            hold_act_q   <= 1'b0;
            hold_key_q   <= 1'b0;
            hold_first_q <= 1'b0;
            hold_cnt_q   <= {HW{1'b0}};
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            arm_q     <= arm_d;
            press_q   <= press_d;
            btn_out_q <= btn_out_d;
            btn_pos_q <= btn_pos_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef KEY_AUTOREPEAT_EN
            hold_act_q   <= hold_act_d;
            hold_key_q   <= hold_key_d;
            hold_first_q <= hold_first_d;
            hold_cnt_q   <= hold_cnt_d;
`endif
        end
    end

endmodule : key_scan

// File: tb/tb_key_scan.sv
// tb_key_scan: directed self-checking bench for key_scan with
// DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_scan;

    localparam int DEB = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk1;
    logic       rst;
    logic       sw1;
    logic [3:0] key_raw;
    int         n_checks;
    int         n_errors;

    key_scan_if bus_if ();

    key_scan #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk1    (clk1),
        .rst     (rst),
        .sw1     (sw1),
        .key_raw (key_raw),
        .bus     (bus_if)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Press keys right after an edge (next edge is edge 0), expect the code at edge 6.
    task automatic press_key(input string tag, input logic [3:0] keys,
                             input logic [3:0] code, input logic [1:0] pos);
        key_raw = keys;
        repeat (6) tick();
        chk({tag, "_early"}, bus_if.btn_out, 4'b1111);
        tick();
        chk({tag, "_code"}, bus_if.btn_out, code);
        chk({tag, "_pos"}, {2'b00, bus_if.btn_pos}, {2'b00, pos});
        tick();
        chk({tag, "_idle"}, bus_if.btn_out, 4'b1111);
        key_raw = 4'b1111;
        repeat (8) tick();
    endtask

    initial begin
        logic [3:0] exp_code;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        sw1      = 1'b1;
        key_raw  = 4'b0000;

        // Reset with all keys held.
        repeat (2) tick();
        chk("reset_out", bus_if.btn_out, 4'b1111);
        chk("reset_pos", {2'b00, bus_if.btn_pos}, 4'b0000);
        rst = 1'b0;
        // Keys held through reset must not fire.
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("held_after_reset", bus_if.btn_out, 4'b1111);
        end
        key_raw = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("release_after_reset", bus_if.btn_out, 4'b1111);
        end

        // Up glitch for 3 cycles: no event.
        key_raw = 4'b1011;
        repeat (3) tick();
        key_raw = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch", bus_if.btn_out, 4'b1111);
        end

        // Clean up press: code exactly at edge 6.
        press_key("up", 4'b1011, 4'b1011, 2'd0);

        // Cursor wrap.
        press_key("right1", 4'b1101, 4'b1101, 2'd1);
        press_key("right2", 4'b1101, 4'b1101, 2'd2);
        press_key("right3", 4'b1101, 4'b1101, 2'd3);
        press_key("right4", 4'b1101, 4'b1101, 2'd0);
        press_key("left1",  4'b1110, 4'b1110, 2'd3);

        // Priority.
        press_key("up_down",    4'b0011, 4'b1011, 2'd3);
        press_key("left_right", 4'b1100, 4'b1101, 2'd0);

        // Mode gating.
        press_key("right5", 4'b1101, 4'b1101, 2'd1);
        sw1 = 1'b0;
        tick();
        chk("run_pos_forced", {2'b00, bus_if.btn_pos}, 4'b0000);
        key_raw = 4'b1110;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("run_left_out", bus_if.btn_out, 4'b1111);
            chk("run_left_pos", {2'b00, bus_if.btn_pos}, 4'b0000);
        end
        key_raw = 4'b1111;
        repeat (8) tick();
        key_raw = 4'b0111;
        repeat (10) tick();
        sw1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mode_entry_held", bus_if.btn_out, 4'b1111);
        end
        key_raw = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mode_entry_release", bus_if.btn_out, 4'b1111);
        end

        // Hold down: first event at edge 6, repeats only in the auto-repeat build.
        key_raw = 4'b0111;
        repeat (6) tick();
        chk("hold_early", bus_if.btn_out, 4'b1111);
        tick();
        chk("hold_first", bus_if.btn_out, 4'b0111);
        chk("hold_pos", {2'b00, bus_if.btn_pos}, 4'b0000);
        for (int e = 7; e <= 40; e++) begin
            tick();
            if (AR && e >= 16 && e <= 31 && ((e - 16) % 3) == 0) begin
                exp_code = 4'b0111;
            end else begin
                exp_code = 4'b1111;
            end
            chk($sformatf("hold_edge%0d", e), bus_if.btn_out, exp_code);
            if (e == 25) begin
                key_raw = 4'b1111;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_scan
